// File: rtl/decode_fifo.sv
// -----------------------------------------------------------------------------
// decode_fifo
//   Buffers words from the decode register stage in a DEPTH-entry
//   first-word-fall-through FIFO. The FIFO drains to the next block over a
//   valid/ready handshake. If a word arrives while the FIFO is full, it is
//   dropped and counted, so the decoder is never stalled.
//
// Ports
//   slowClk    in   clock; all state updates on posedge
//   reset      in   asynchronous reset, active low
//   inValid    in   dataIn carries a new decoded word
//   dataIn     in   decoded word
//   inReady    out  FIFO accepts a word this cycle
//   outValid   out  dataOut holds the head entry
//   outReady   in   consumer takes dataOut this cycle
//   dataOut    out  head entry, '0 when empty
//   count      out  occupancy, 0..DEPTH
//   dropCount  out  words lost to overflow, saturating
// -----------------------------------------------------------------------------
module decode_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int DROP_WIDTH = 8
) (
  input  logic                       slowClk,
  input  logic                       reset,
  input  logic                       inValid,
  input  logic [DATA_WIDTH-1:0]      dataIn,
  output logic                       inReady,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [DATA_WIDTH-1:0]      dataOut,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DROP_WIDTH-1:0]      dropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic [DROP_WIDTH-1:0] drop_q,   drop_d;
  logic                  ready_q,  ready_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic full, empty, in_ready, out_valid, push, pop, drop;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    in_ready  = ready_q & ~full;
    out_valid = ~empty;
    push      = inValid & in_ready;
    pop       = out_valid & outReady;
    // A word that arrives while full is lost; there is no bypass through a
    // slot freed by a same-cycle pop.
    drop      = inValid & ready_q & full;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    // The ready flag goes high on the first edge after reset is released.
    ready_d  = 1'b1;

    // The pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop && (drop_q != '1)) drop_d = drop_q + DROP_WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only. Then every flop
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge slowClk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      ready_q  <= ready_d;
    end
  end

  // NOTE: the storage array has no reset. The count and pointers decide which
  // entries are valid, so stale contents are never seen. Leaving the reset off
  // also lets synthesis map the array onto plain registers or RAM.
  always_ff @(posedge slowClk) begin
    if (push) mem_q[wr_ptr_q] <= dataIn;
  end

  // dataOut is read from registered storage, so no combinational path runs
  // from dataIn to dataOut. A pushed word becomes visible the cycle after it
  // is written.
  always_comb begin
    inReady   = in_ready;
    outValid  = out_valid;
    dataOut   = out_valid ? mem_q[rd_ptr_q] : '0;
    count     = count_q;
    dropCount = drop_q;
  end

endmodule
